bv_result_reduce: RTL and testbench

//  Pipelined, parametrised bit-vector reduction for the BV lookup stage: combines SRAM_NUM
//  per-slice match vectors into one result vector under a runtime mode (AND/OR/masked AND/bypass).

---
 rtl/bv_result_reduce.sv | 187 ++++++++++++++++++
 tb/tb_bv_result_reduce.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bv_result_reduce.sv
// bv_result_reduce: pipelined reduction of SRAM_NUM per-slice match vectors into one
// result vector. Modes: AND of all slices, OR of all slices, AND of the slices enabled
// in slice_mask_i, or pass slice 0 through. Also produces a hit flag and the index of
// the lowest set bit for the action lookup downstream.
// The pipe has a binary tree with one register level per tree level, then a final output
// register. It has valid/ready on both sides and stalls as a whole when backpressured.
// Optional feature: define BV_REDUCE_POPCNT_EN to add popcnt_o (set-bit count of result_o).
module bv_result_reduce #(
    parameter int  RESULT_WIDTH = 64,
    parameter int  SRAM_NUM     = 4,
    parameter int  MODE_WIDTH   = 2,
    localparam int IDX_WIDTH    = $clog2(RESULT_WIDTH)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [RESULT_WIDTH*SRAM_NUM-1:0] result_i,
    input  logic [MODE_WIDTH-1:0]            mode_i,
    input  logic [SRAM_NUM-1:0]              slice_mask_i,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [RESULT_WIDTH-1:0]          result_o,
    output logic                             match_o,
    output logic [IDX_WIDTH-1:0]             match_idx_o
`ifdef BV_REDUCE_POPCNT_EN
    ,
    output logic [$clog2(RESULT_WIDTH+1)-1:0] popcnt_o
`endif
);

    localparam int LEVELS = $clog2(SRAM_NUM);
    // Leaves are padded up to a power of two so every tree level pairs evenly.
    localparam int NP     = 1 << LEVELS;

    localparam logic [MODE_WIDTH-1:0] MODE_OR   = MODE_WIDTH'(1);
    localparam logic [MODE_WIDTH-1:0] MODE_MASK = MODE_WIDTH'(2);
    localparam logic [MODE_WIDTH-1:0] MODE_S0   = MODE_WIDTH'(3);

    typedef logic [RESULT_WIDTH-1:0] vec_t;

    // Every stage advances together. A bubble is not squeezed out, so the latency stays fixed.
    logic advance;
    assign advance  = ~out_valid | out_ready;
    assign in_ready = advance;

    // Only OR mode changes the operator. The other modes become AND over pre-masked leaves.
    logic leaf_or;
    logic mask_all_off;
    assign leaf_or      = (mode_i == MODE_OR);
    assign mask_all_off = (mode_i == MODE_MASK) && (slice_mask_i == '0);

    // Stage 0: pre-mask each slice so that the tree only needs AND or OR.
    logic [NP*RESULT_WIDTH-1:0] leaf_flat;
    for (genvar j = 0; j < NP; j++) begin : g_leaf
        if (j < SRAM_NUM) begin : g_real
            // A disabled slice becomes the AND identity. With an empty mask, zero is forced
            // so that result_o reads 0 and not all-ones.
            assign leaf_flat[j*RESULT_WIDTH +: RESULT_WIDTH] =
                mask_all_off                              ? '0 :
                (mode_i == MODE_MASK && !slice_mask_i[j]) ? '1 :
                (mode_i == MODE_S0 && j != 0)             ? '1 :
                result_i[j*RESULT_WIDTH +: RESULT_WIDTH];
        end else begin : g_pad
            // A padding leaf is the identity of whichever operator this vector uses.
            assign leaf_flat[j*RESULT_WIDTH +: RESULT_WIDTH] = leaf_or ? '0 : '1;
        end
    end

    vec_t tree_data;
    logic tree_valid;

    if (LEVELS == 0) begin : g_no_tree
        assign tree_data  = leaf_flat;
        assign tree_valid = in_valid;
    end else begin : g_tree
        for (genvar l = 1; l <= LEVELS; l++) begin : g_lvl
            localparam int NN = NP >> l;

            logic [2*NN*RESULT_WIDTH-1:0] src_data;
            logic                         src_valid;
            logic                         src_or;
            logic [NN*RESULT_WIDTH-1:0]   data_q;
            logic                         valid_q;

            if (l == 1) begin : g_src
                assign src_data  = leaf_flat;
                assign src_valid = in_valid;
                assign src_or    = leaf_or;
            end else begin : g_src
                assign src_data  = g_lvl[l-1].data_q;
                assign src_valid = g_lvl[l-1].valid_q;
                assign src_or    = g_lvl[l-1].g_op.or_q;
            end

            // The operator flag moves with the data. Only levels that feed another tree
            // level need to keep it.
            if (l < LEVELS) begin : g_op
                logic or_q;
                // Register the operator flag for the next tree level.
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        or_q <= 1'b0;
                    end else if (advance) begin
                        or_q <= src_or;
                    end
                end
            end

            // The stage valid is cleared by reset so that no vector in flight survives it.
            always_ff @(posedge clk or negedge rst_n) begin
                // NOTE: all sequential state uses non-blocking assignment, so every stage
                // samples the value its predecessor held before this clock edge.
                if (!rst_n) begin
                    valid_q <= 1'b0;
                end else if (advance) begin
                    valid_q <= src_valid;
                end
            end

            // Pairwise reduction of the previous level into this level's registers.
            always_ff @(posedge clk) begin
                // NOTE: the data registers are deliberately left without reset. valid_q
                // qualifies them, so a reset only costs routing and buys nothing.
                if (advance) begin
                    for (int k = 0; k < NN; k++) begin
                        data_q[k*RESULT_WIDTH +: RESULT_WIDTH] <= src_or
                            ? (src_data[(2*k)*RESULT_WIDTH +: RESULT_WIDTH] |
                               src_data[(2*k+1)*RESULT_WIDTH +: RESULT_WIDTH])
                            : (src_data[(2*k)*RESULT_WIDTH +: RESULT_WIDTH] &
                               src_data[(2*k+1)*RESULT_WIDTH +: RESULT_WIDTH]);
                    end
                end
            end
        end

        assign tree_data  = g_lvl[LEVELS].data_q;
        assign tree_valid = g_lvl[LEVELS].valid_q;
    end

    // Priority encoder: the lowest set bit wins, and an all-zero vector gives index 0.
    logic [IDX_WIDTH-1:0] idx_d;
    always_comb begin
        // NOTE: the default is assigned before the loop, so every path drives idx_d and no
        // latch is inferred.
        idx_d = '0;
        for (int i = RESULT_WIDTH - 1; i >= 0; i--) begin
            if (tree_data[i]) idx_d = IDX_WIDTH'(i);
        end
    end

`ifdef BV_REDUCE_POPCNT_EN
    localparam int POP_WIDTH = $clog2(RESULT_WIDTH + 1);
    logic [POP_WIDTH-1:0] pop_d;
    // Count the set bits of the vector that is about to be registered.
    always_comb begin
        pop_d = '0;
        for (int i = 0; i < RESULT_WIDTH; i++) begin
            pop_d = pop_d + POP_WIDTH'(tree_data[i]);
        end
    end
`endif

    // Output register. The outputs reload only on a valid advance, so they hold while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            result_o    <= '0;
            match_o     <= 1'b0;
            match_idx_o <= '0;
`ifdef BV_REDUCE_POPCNT_EN
            popcnt_o    <= '0;
`endif
        end else if (advance) begin
            out_valid <= tree_valid;
            if (tree_valid) begin
                result_o    <= tree_data;
                match_o     <= |tree_data;
                match_idx_o <= idx_d;
`ifdef BV_REDUCE_POPCNT_EN
                popcnt_o    <= pop_d;
`endif
            end
        end
    end

endmodule

// File: tb/tb_bv_result_reduce.sv
// Self-checking bench for bv_result_reduce.
// Accepted inputs go through a plain reference reduction into an expected-output queue.
// A negedge monitor compares every output transfer with the head of that queue. It also
// checks that the outputs hold while stalled.
module tb_bv_result_reduce;

    localparam int W  = 64;
    localparam int N  = 4;
    localparam int MW = 2;
    localparam int IW = $clog2(W);
    localparam int PW = $clog2(W + 1);

    typedef struct {
        logic [W-1:0]  res;
        logic          match;
        logic [IW-1:0] idx;
        logic [PW-1:0] pop;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W*N-1:0] result_i;
    logic [MW-1:0] mode_i;
    logic [N-1:0]  slice_mask_i;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  result_o;
    logic          match_o;
    logic [IW-1:0] match_idx_o;
`ifdef BV_REDUCE_POPCNT_EN
    logic [PW-1:0] popcnt_o;
`endif

    bv_result_reduce #(
        .RESULT_WIDTH(W),
        .SRAM_NUM    (N),
        .MODE_WIDTH  (MW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .result_i    (result_i),
        .mode_i      (mode_i),
        .slice_mask_i(slice_mask_i),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result_o    (result_o),
        .match_o     (match_o),
        .match_idx_o (match_idx_o)
`ifdef BV_REDUCE_POPCNT_EN
        ,
        .popcnt_o    (popcnt_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int           n_checks;
    int           n_pass;
    exp_t         exp_q[$];
    logic         rand_rdy;
    logic [W-1:0] last_res;
    logic         last_match;
    logic [IW-1:0] last_idx;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [W*N-1:0] pack4(input logic [W-1:0] s0, s1, s2, s3);
        return {s3, s2, s1, s0};
    endfunction

    // Reference reduction computed directly from the mode rules.
    function automatic exp_t model(input logic [W*N-1:0] v, input logic [MW-1:0] m,
                                   input logic [N-1:0] k);
        exp_t         e;
        logic [W-1:0] r;
        case (m)
            2'd1: begin
                r = '0;
                for (int s = 0; s < N; s++) r = r | v[s*W +: W];
            end
            2'd2: begin
                if (k == '0) r = '0;
                else begin
                    r = '1;
                    for (int s = 0; s < N; s++) if (k[s]) r = r & v[s*W +: W];
                end
            end
            2'd3: r = v[W-1:0];
            default: begin
                r = '1;
                for (int s = 0; s < N; s++) r = r & v[s*W +: W];
            end
        endcase
        e.res   = r;
        e.match = (r != '0);
        e.idx   = '0;
        for (int b = 0; b < W; b++) begin
            if (r[b]) begin
                e.idx = IW'(b);
                break;
            end
        end
        e.pop = PW'($countones(r));
        return e;
    endfunction

    // Present one vector, wait (bounded) for it to be accepted, then drop in_valid.
    // Called at posedge+1.
    task automatic send(input logic [W*N-1:0] v, input logic [MW-1:0] m, input logic [N-1:0] k);
        int waited = 0;
        result_i = v; mode_i = m; slice_mask_i = k; in_valid = 1'b1;
        do begin
            @(negedge clk);
            waited++;
        end while (!in_ready && waited < 200);
        check("accept_in_time", in_ready, 1'b1);
        if (in_ready) exp_q.push_back(model(v, m, k));
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Wait (bounded) for the next output, then return at posedge+1 after the transfer.
    task automatic wait_out();
        int waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!out_valid && waited < 50);
        check("output_in_time", out_valid, 1'b1);
        @(posedge clk); #1;
    endtask

    // Compare every output transfer against the model queue and check that a stalled output holds.
    task automatic monitor();
        logic         held = 1'b0;
        logic [W-1:0] held_res = '0;
        exp_t         e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                held = 1'b0;
            end else begin
                if (held) begin
                    check("stall_valid_held", out_valid, 1'b1);
                    check("stall_result_held", result_o, held_res);
                end
                held     = out_valid && !out_ready;
                held_res = result_o;
                if (out_valid && out_ready) begin
                    check("output_was_expected", exp_q.size() != 0, 1'b1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("result_o", result_o, e.res);
                        check("match_o", match_o, e.match);
                        check("match_idx_o", match_idx_o, e.idx);
`ifdef BV_REDUCE_POPCNT_EN
                        check("popcnt_o", popcnt_o, e.pop);
`endif
                        last_res   = result_o;
                        last_match = match_o;
                        last_idx   = match_idx_o;
                    end
                end
            end
        end
    endtask

    task automatic ready_toggler();
        forever begin
            @(posedge clk); #1;
            if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
        end
    endtask

    initial begin
        logic [W*N-1:0] v;
        logic [W-1:0]   common;
        int             lat;
        int             seen;
        int             waited;

        n_checks = 0; n_pass = 0;
        rst_n = 1'b0; in_valid = 1'b0; result_i = '0; mode_i = '0; slice_mask_i = '0;
        out_ready = 1'b1; rand_rdy = 1'b0;
        last_res = '0; last_match = 1'b0; last_idx = '0;
        fork
            monitor();
            ready_toggler();
            begin
                #2_000_000;
                $display("FAIL watchdog: simulation did not finish");
                $fatal(1, "watchdog");
            end
        join_none

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_result_o", result_o, '0);
        check("rst_match_o", match_o, 1'b0);
        check("rst_match_idx_o", match_idx_o, '0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready", in_ready, 1'b1);

        // Mode 0: AND of all slices, with a latency of 3 cycles.
        v = pack4(64'hFF00, 64'hF0F0, 64'hFFFF, 64'hF000);
        check("model_and", model(v, 2'd0, 4'hF).res, 64'hF000);
        send(v, 2'd0, 4'hF);
        lat = 1;
        while (lat < 20) begin
            @(negedge clk);
            if (out_valid) break;
            lat++;
        end
        check("latency_cycles", lat, 3);
        @(posedge clk); #1;
        check("and_result", last_res, 64'hF000);
        check("and_match", last_match, 1'b1);
        check("and_idx", last_idx, 12);

        // Mode 2 with a mask, then with an empty mask.
        v = pack4(64'h0F, 64'h1234_5678_0000_0000, 64'h03, 64'hFFFF_0000_0000_0000);
        check("model_masked", model(v, 2'd2, 4'b0101).res, 64'h03);
        send(v, 2'd2, 4'b0101);
        wait_out();
        check("masked_result", last_res, 64'h03);
        check("masked_idx", last_idx, 0);
        send(v, 2'd2, 4'b0000);
        wait_out();
        check("mask0_result", last_res, 64'h0);
        check("mask0_match", last_match, 1'b0);
        check("mask0_idx", last_idx, 0);

        // Mode 1: OR of all slices, with the top bit set. Mode 3: pass slice 0.
        v = pack4(64'h8000_0000_0000_0000, 64'h0, 64'h0, 64'h0);
        send(v, 2'd1, 4'h0);
        wait_out();
        check("or_result", last_res, 64'h8000_0000_0000_0000);
        check("or_idx", last_idx, 63);
        v = pack4(64'hDEAD_BEEF_0000_0100, {$urandom, $urandom}, {$urandom, $urandom}, 64'h0);
        send(v, 2'd3, 4'h0);
        wait_out();
        check("slice0_result", last_res, 64'hDEAD_BEEF_0000_0100);
        check("slice0_idx", last_idx, 8);

        // 20 random vectors with random gaps and random backpressure.
        rand_rdy = 1'b1;
        for (int n = 0; n < 20; n++) begin
            common = {$urandom, $urandom};
            if ($urandom_range(0, 7) == 0)
                v = '0;
            else
                v = pack4(common | {$urandom, $urandom}, common | {$urandom, $urandom},
                          common | {$urandom, $urandom}, common | {$urandom, $urandom});
            send(v, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
        end
        rand_rdy = 1'b0;
        @(posedge clk); #2;
        out_ready = 1'b1;
        waited = 0;
        while (exp_q.size() != 0 && waited < 200) begin
            @(posedge clk);
            waited++;
        end
        #1;
        check("random_drained", exp_q.size(), 0);

        // Reset while two vectors are in flight, with one of them stalled at the output.
        out_ready = 1'b0;
        send(pack4(64'hFF, 64'hFF, 64'hFF, 64'hFF), 2'd0, 4'hF);
        send(pack4(64'hF0, 64'h0, 64'h0, 64'h0), 2'd1, 4'h0);
        waited = 0;
        while (!out_valid && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("flight_out_valid", out_valid, 1'b1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_result_o", result_o, '0);
        check("midrst_match_o", match_o, 1'b0);
        check("midrst_match_idx_o", match_idx_o, '0);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        out_ready = 1'b1;
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("midrst_no_ghosts", seen, 0);

        // The pipe still works after the reset.
        @(posedge clk); #1;
        send(pack4(64'h0, 64'h30, 64'h0, 64'h0), 2'd1, 4'h0);
        wait_out();
        check("post_rst_result", last_res, 64'h30);
        check("post_rst_idx", last_idx, 4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
